// File: rtl/rr_arbiter.sv
// Registered N-way round-robin / fixed-priority arbiter with optional grant holding.
// Define ARB_TIMEOUT_EN to bound hold duration to TIMEOUT cycles (grant_timeout pulse).
module rr_arbiter_prio_enc #(
    parameter int WIDTH     = 4,
    parameter bit MSB_FIRST = 1'b0,
    localparam int EW       = $clog2(WIDTH)
) (
    input  logic [WIDTH-1:0] req,
    output logic             valid,
    output logic [EW-1:0]    idx
);
    always_comb begin
        valid = 1'b0;
        idx   = '0;
        for (int i = 0; i < WIDTH; i++) begin
            if (!valid && req[MSB_FIRST ? WIDTH-1-i : i]) begin
                valid = 1'b1;
                idx   = EW'(MSB_FIRST ? WIDTH-1-i : i);
            end
        end
    end
endmodule

module rr_arbiter #(
    parameter int    PORTS        = 4,
    parameter string TYPE         = "ROUND_ROBIN",
    parameter string BLOCK        = "REQUEST",
    parameter string LSB_PRIORITY = "LOW",
    parameter int    TIMEOUT      = 256
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [PORTS-1:0]         request,
    input  logic [PORTS-1:0]         acknowledge,
    output logic [PORTS-1:0]         grant,
    output logic                     grant_valid,
    output logic [$clog2(PORTS)-1:0] grant_encoded,
    output logic                     grant_timeout
);
    localparam int EW       = $clog2(PORTS);
    localparam bit IS_PRIO  = (TYPE == "PRIORITY");
    localparam bit HOLD_REQ = (BLOCK == "REQUEST") || (BLOCK == "ACKNOWLEDGE");
    localparam bit HOLD_ACK = (BLOCK == "ACKNOWLEDGE");
    localparam bit MSB_WINS = (LSB_PRIORITY == "HIGH");

    if (PORTS < 2 || TIMEOUT < 2) begin : g_bad_cfg
        $error("rr_arbiter: PORTS and TIMEOUT must both be >= 2");
    end

    logic [PORTS-1:0] grant_q, grant_d, mask_q, mask_d, masked;
    logic [EW-1:0]    enc_q, enc_d, m_idx, r_idx, win_idx;
    logic             valid_q, valid_d, m_valid, r_valid;
    logic             hold_raw, hold, expire;

    assign masked = request & mask_q;

    rr_arbiter_prio_enc #(.WIDTH(PORTS), .MSB_FIRST(MSB_WINS)) u_enc_masked (
        .req(masked), .valid(m_valid), .idx(m_idx)
    );
    rr_arbiter_prio_enc #(.WIDTH(PORTS), .MSB_FIRST(MSB_WINS)) u_enc_raw (
        .req(request), .valid(r_valid), .idx(r_idx)
    );

    // An empty mask falls through to the raw encode, which is the wrap-around.
    assign win_idx  = (m_valid && !IS_PRIO) ? m_idx : r_idx;
    assign hold_raw = HOLD_REQ && valid_q && |(grant_q & request)
                      && !(HOLD_ACK && |(grant_q & acknowledge));
    assign hold     = hold_raw && !expire;

    always_comb begin
        grant_d = grant_q;
        enc_d   = enc_q;
        valid_d = valid_q;
        mask_d  = mask_q;
        if (!hold) begin
            grant_d = '0;
            if (r_valid) grant_d[win_idx] = 1'b1;
            enc_d   = win_idx;
            valid_d = r_valid;
            if (r_valid) begin
                for (int j = 0; j < PORTS; j++)
                    mask_d[j] = MSB_WINS ? (j < int'(win_idx)) : (j > int'(win_idx));
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            grant_q <= '0;
            enc_q   <= '0;
            valid_q <= 1'b0;
            mask_q  <= '1;
        end else begin
            grant_q <= grant_d;
            enc_q   <= enc_d;
            valid_q <= valid_d;
            mask_q  <= mask_d;
        end
    end

`ifdef ARB_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT);
    logic [CW-1:0] hold_cnt_q, hold_cnt_d;
    logic          timeout_q, timeout_d;

    // Expiry lands on the edge after TIMEOUT visible cycles of the same grant.
    assign expire = hold_raw && (hold_cnt_q == CW'(TIMEOUT - 1));

    always_comb begin
        hold_cnt_d = hold ? hold_cnt_q + CW'(1) : '0;
        timeout_d  = expire;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hold_cnt_q <= '0;
            timeout_q  <= 1'b0;
        end else begin
            hold_cnt_q <= hold_cnt_d;
            timeout_q  <= timeout_d;
        end
    end

    assign grant_timeout = timeout_q;
`else
    assign expire        = 1'b0;
    assign grant_timeout = 1'b0;
`endif

    assign grant         = grant_q;
    assign grant_valid   = valid_q;
    assign grant_encoded = enc_q;
endmodule

// File: doc/rr_arbiter.md
# rr_arbiter

Registered N-way arbiter that shares one downstream resource (bus, port, memory channel) between up to PORTS requesters. It uses two priority-encoder instances: one on masked requests, one on raw requests. The encoders provide either fixed-priority or round-robin selection. Optional request- or acknowledge-based grant holding supports multi-cycle transfers. The block sits between the requesters and the shared datapath mux, and drives the mux select via `grant_encoded`.

## Interface
- `PORTS`, 4: number of requesters, ≥2.
- `TYPE`, "ROUND_ROBIN": "ROUND_ROBIN" or "PRIORITY" (fixed, mask ignored).
- `BLOCK`, "REQUEST": "NONE", "REQUEST" or "ACKNOWLEDGE"; grant hold policy.
- `LSB_PRIORITY`, "LOW": "LOW" means the lowest index wins; "HIGH" means the highest index wins.
- `TIMEOUT`, 256: maximum hold cycles; used only when `ARB_TIMEOUT_EN` is defined; ≥2.
- `clk` in 1: single clock, all logic on the rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `request` in PORTS: per-port request level.
- `acknowledge` in PORTS: per-port release pulse (BLOCK="ACKNOWLEDGE" only).
- `grant` out PORTS: one-hot registered grant.
- `grant_valid` out 1: `|grant`.
- `grant_encoded` out $clog2(PORTS): index of the granted port.
- `grant_timeout` out 1: one-cycle pulse on forced release.

## Operation
- State: `grant`, `grant_encoded`, `grant_valid`, `mask[PORTS]`, and (with the macro) `hold_cnt`.
- Arbitration result each cycle:
  - If `masked = request & mask` is non-zero, the winner is its priority encode.
  - Otherwise the winner is the priority encode of raw `request`.
  - With TYPE="PRIORITY", the winner is always the encode of raw `request`.
- Hold condition, when a grant is active on port g:
  - NONE: never held.
  - REQUEST: held while `request[g]`=1.
  - ACKNOWLEDGE: held until a cycle with `acknowledge[g]`=1 and `request[g]`=1.
    - Acknowledge on a non-granted port is ignored.
    - Acknowledge with `request[g]`=0 also releases.
- Each edge:
  - If a grant is active and the hold condition is true, `grant` is unchanged.
  - Otherwise `grant` is loaded with the arbitration result. If no requests are pending, `grant` is loaded with 0 and `grant_valid` drops.
- Mask update, only on an edge that issues a new grant to index i:
  - LSB_PRIORITY="LOW": `mask` = bits strictly above i.
  - LSB_PRIORITY="HIGH": `mask` = bits strictly below i.
  - With an all-zero mask, arbitration falls back to raw requests, which gives wrap-around.
- Release and re-grant happen on the same edge, with no idle cycle. A released port that is still requesting is last in round-robin order.
- A port whose request drops before it is granted is never granted.

## Timing
- Reset values: `grant`=0, `grant_valid`=0, `grant_encoded`=0, `grant_timeout`=0, `mask`=all ones, `hold_cnt`=0.
- Latency:
  - Request to grant: 1 cycle when the resource is idle.
  - Release to next grant: 1 edge.
- Outputs are purely registered. There is no combinational path from `request` or `acknowledge` to any output.
- BLOCK="NONE": grant can move every cycle; round-robin rotation happens per cycle among active requesters.
- Simultaneous release and new request arrival: the new request competes in the same arbitration.
- Reset mid-grant: all state clears immediately (asynchronous). After reset deassertion, the first arbitration treats port 0 (LOW) or port PORTS-1 (HIGH) as highest priority.

## Configuration
- Macro: `ARB_TIMEOUT_EN`.
- Defined:
  - `hold_cnt` clears on each new grant and increments each held cycle.
  - When the grant has been held `TIMEOUT` cycles, the hold condition is forced false on that edge and re-arbitration occurs with the normal mask.
  - `grant_timeout` pulses high for that single cycle.
  - This applies only to REQUEST and ACKNOWLEDGE modes.
- Undefined: no counter is present, `grant_timeout` is tied 0, and `TIMEOUT` is unused. Holds are unbounded.

## Test plan
- **Reset and first grant.** Settings: PORTS=4, ROUND_ROBIN, REQUEST. `request`=4'b1010 held from reset release.
  - Required: after 1 edge, `grant`=4'b0010, `grant_encoded`=1.
  - Drop `request[1]`: next edge gives `grant`=4'b1000.
- **Round-robin rotation.** Setting: BLOCK="NONE". `request`=4'b1111 constant.
  - Required: grant index sequence 0,1,2,3,0,1…, one per cycle, `grant_valid`=1 throughout.
- **Fixed priority.** Settings: TYPE="PRIORITY", NONE, `request`=4'b1100.
  - LSB_PRIORITY="LOW": index stays 2.
  - LSB_PRIORITY="HIGH": index stays 3.
- **Acknowledge hold.** Settings: ACKNOWLEDGE, `request`=4'b0011.
  - Port 0 is granted and held 5 cycles despite pending port 1.
  - A pulse on `acknowledge[1]` is ignored.
  - A pulse on `acknowledge[0]` moves the grant to port 1 on the next edge.
- **Timeout** (macro defined). Settings: TIMEOUT=8, REQUEST, `request`=4'b0101 constant.
  - Required: port 0 is held 8 cycles, then `grant_timeout` pulses once and the grant moves to port 2.
  - Without the macro, port 0 is held indefinitely.
- **Reset mid-grant.** Assert `rst` while port 3 is granted.
  - Required: all outputs are 0 before the next edge.
  - After release with `request`=4'b1001, port 0 is granted.
